// File: rtl/inv_mixcolumn_seq.sv
// AES InvMixColumns engine: one 128-bit state in, LANES columns per cycle, result held until taken.
// Optional: define INV_MIXCOL_DUAL_EN to add the fwd port selecting forward MixColumns per block.
module inv_mixcolumn_seq #(
   parameter int LANES = 1
) (
   input  logic         clk,
   input  logic         rst,
`ifdef INV_MIXCOL_DUAL_EN
   input  logic         fwd,
`endif
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] data_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_out
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [1:0] LAST_COL = 2'(4 - LANES);
   localparam logic [1:0] COL_STEP = 2'(LANES);

   logic [1:0]   state_reg;
   logic [1:0]   col_cnt_reg;
   logic [127:0] cap_reg;
   logic [127:0] data_out_reg;
`ifdef INV_MIXCOL_DUAL_EN
   logic         fwd_reg;
`endif

   logic [1:0]  lane_col [LANES];
   logic [31:0] lane_res [LANES];

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Column c sits at bits 127-32c down, i.e. base 32*(3-c); 3-c is ~c for two bits.
   function automatic logic [6:0] col_base(input logic [1:0] c);
      return {~c, 5'b00000};
   endfunction

   function automatic logic [31:0] inv_col(input logic [31:0] col);
      logic [7:0] a  [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31-8*i -: 8];
         x2    = xtime(a[i]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

`ifdef INV_MIXCOL_DUAL_EN
   function automatic logic [31:0] fwd_col(input logic [31:0] col);
      logic [7:0] a  [4];
      logic [7:0] m2 [4];
      logic [7:0] m3 [4];
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31-8*i -: 8];
         m2[i] = xtime(a[i]);
         m3[i] = m2[i] ^ a[i];
      end
      return {m2[0] ^ m3[1] ^ a[2]  ^ a[3],
              a[0]  ^ m2[1] ^ m3[2] ^ a[3],
              a[0]  ^ a[1]  ^ m2[2] ^ m3[3],
              m3[0] ^ a[1]  ^ a[2]  ^ m2[3]};
   endfunction
`endif

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic [31:0] lane_in;
         assign lane_col[gi] = col_cnt_reg + 2'(gi);
         assign lane_in      = cap_reg[col_base(lane_col[gi]) +: 32];
`ifdef INV_MIXCOL_DUAL_EN
         assign lane_res[gi] = fwd_reg ? fwd_col(lane_in) : inv_col(lane_in);
`else
         assign lane_res[gi] = inv_col(lane_in);
`endif
      end
   endgenerate

   // Combinational from out_ready so a new block can enter in the same cycle the result leaves.
   assign in_ready  = (state_reg == IDLE) | ((state_reg == DONE) & out_ready);
   assign out_valid = (state_reg == DONE);
   assign data_out  = data_out_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         col_cnt_reg  <= 2'd0;
         cap_reg      <= '0;
         data_out_reg <= '0;
`ifdef INV_MIXCOL_DUAL_EN
         fwd_reg      <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               if (in_valid && in_ready) begin
                  cap_reg     <= data_in;
                  col_cnt_reg <= 2'd0;
                  state_reg   <= BUSY;
`ifdef INV_MIXCOL_DUAL_EN
                  fwd_reg     <= fwd;
`endif
               end else if (state_reg == DONE && out_ready) begin
                  state_reg <= IDLE;
               end
            end
            BUSY: begin
               for (int i = 0; i < LANES; i++) begin
                  data_out_reg[col_base(lane_col[i]) +: 32] <= lane_res[i];
               end
               col_cnt_reg <= col_cnt_reg + COL_STEP;
               if (col_cnt_reg == LAST_COL) begin
                  state_reg <= DONE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_mixcolumn_seq.sv
// Directed-vector bench for inv_mixcolumn_seq: known vectors, backpressure, back-to-back, async reset.
module tb_inv_mixcolumn_seq;

   localparam int LANES = 1;
   localparam int LAT   = 4 / LANES;

   localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
   localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
   localparam logic [127:0] V2_IN  = 128'hc6c6c6c6_c6c6c6c6_4d7ebdf8_00000000;
   localparam logic [127:0] V2_OUT = 128'hc6c6c6c6_c6c6c6c6_2d26314c_00000000;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] data_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] data_out;
`ifdef INV_MIXCOL_DUAL_EN
   logic         fwd;
`endif

   int checks = 0;
   int errors = 0;
   int n;

   always #5 clk = ~clk;

   inv_mixcolumn_seq #(.LANES(LANES)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef INV_MIXCOL_DUAL_EN
      .fwd       (fwd),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Presents one block at a negedge; returns 1 ns after the accepting edge with in_valid low.
   task automatic send(input logic [127:0] d);
      @(negedge clk);
      data_in  = d;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      $display("txn accept data_in=%h", d);
   endtask

   task automatic wait_out(output int cnt);
      cnt = 0;
      while (!out_valid && cnt < 50) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      $display("txn result after %0d edges data_out=%h", cnt, data_out);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      data_in   = '0;
`ifdef INV_MIXCOL_DUAL_EN
      fwd       = 1'b0;
`endif
      #12;
      check("rst_in_ready",  128'(in_ready),  128'(1));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_data_out",  data_out,        '0);
      @(negedge clk);
      rst = 1'b0;

      // Known vector with downstream always ready
      send(V1_IN);
      check("busy_in_ready", 128'(in_ready), 128'(0));
      wait_out(n);
      check("known_latency",   128'(n),         128'(LAT));
      check("known_out_valid", 128'(out_valid), 128'(1));
      check("known_data",      data_out,        V1_OUT);
      check("done_in_ready",   128'(in_ready),  128'(1));
      @(posedge clk);
      #1;
      check("known_drop", 128'(out_valid), 128'(0));

      // Backpressure: result must hold while out_ready is low
      out_ready = 1'b0;
      send(V2_IN);
      wait_out(n);
      check("bp_latency", 128'(n), 128'(LAT));
      check("bp_data",    data_out, V2_OUT);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("bp_hold_valid", 128'(out_valid), 128'(1));
         check("bp_hold_data",  data_out,        V2_OUT);
         check("bp_in_ready",   128'(in_ready),  128'(0));
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      check("bp_ready_comb", 128'(in_ready), 128'(1));
      @(posedge clk);
      #1;
      check("bp_release", 128'(out_valid), 128'(0));
      $display("txn backpressure released");

      // Back-to-back: in_valid stays high, second block enters in the DONE cycle
      @(negedge clk);
      data_in  = V1_IN;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      data_in = V2_IN;
      wait_out(n);
      check("b2b_lat1",  128'(n), 128'(LAT));
      check("b2b_data1", data_out, V1_OUT);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("b2b_gap_valid", 128'(out_valid), 128'(0));
      wait_out(n);
      check("b2b_lat2",  128'(n), 128'(LAT));
      check("b2b_data2", data_out, V2_OUT);
      @(posedge clk);
      #1;
      check("b2b_idle", 128'(out_valid), 128'(0));

      // Async reset while busy
      send(V1_IN);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("arst_out_valid", 128'(out_valid), 128'(0));
      check("arst_data_out",  data_out,        '0);
      check("arst_in_ready",  128'(in_ready),  128'(1));
      $display("txn async reset applied");
      @(negedge clk);
      rst = 1'b0;
      send(V2_IN);
      wait_out(n);
      check("post_rst_lat",  128'(n), 128'(LAT));
      check("post_rst_data", data_out, V2_OUT);
      @(posedge clk);
      #1;

`ifdef INV_MIXCOL_DUAL_EN
      fwd = 1'b1;
      send(V1_OUT);
      fwd = 1'b0;
      wait_out(n);
      check("fwd_lat",  128'(n), 128'(LAT));
      check("fwd_data", data_out, V1_IN);
      @(posedge clk);
      #1;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
